// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file write demux.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } wr_state_e;

endpackage

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot decoder with enable; output is all zero when disabled.
module decoder_5to32 (
    input  logic        en,
    input  logic [4:0]  addr,
    output logic [31:0] onehot
);

    // Decode the address into a single asserted bit
    always_comb begin
        onehot = 32'd0;
        if (en) begin
            onehot = 32'd1 << addr;
        end else begin
            onehot = 32'd0;
        end
    end

endmodule

// File: rtl/regfile_write_demux.sv
// Register file with a one-deep pending write stage, stall handling and commit counter.
// Optional macro REGFILE_WR_BYPASS_EN forwards pending data to the read port.
module regfile_write_demux
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              freeze,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [31:0]       we_onehot,
    output logic [15:0]       commit_cnt,
    output logic              busy
);

    wr_state_e               state_r;
    wr_state_e               state_nxt_s;
    logic [ADDR_W-1:0]       pend_addr_r;
    logic [DATA_W-1:0]       pend_data_r;
    logic [CNT_W-1:0]        commit_cnt_r;
    logic [DATA_W-1:0]       regs_r [NUM_REGS];
    logic                    wr_ready_s;
    logic                    commit_s;
    logic                    count_s;
    logic                    accept_s;
    logic [31:0]             we_onehot_s;
    logic [DATA_W-1:0]       rd_data_s;

    // Next-state, handshake and commit decision
    always_comb begin
        state_nxt_s = state_r;
        wr_ready_s  = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wr_ready_s = 1'b1;
                if (wr_valid) begin
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                wr_ready_s = !freeze;
                if (freeze) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    commit_s = 1'b1;
                    if (wr_valid) begin
                        state_nxt_s = ST_PEND;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                wr_ready_s = 1'b0;
                if (freeze) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign accept_s = wr_valid & wr_ready_s;
    // Writes to index 0 are dropped: no enable, no count
    assign count_s  = commit_s & (pend_addr_r != 5'd0);

    decoder_5to32 u_dec (
        .en     (count_s),
        .addr   (pend_addr_r),
        .onehot (we_onehot_s)
    );

    // FSM state, pending slot and commit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pend_addr_r  <= 5'd0;
            pend_data_r  <= '0;
            commit_cnt_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                pend_addr_r <= wr_addr;
                pend_data_r <= wr_data;
            end
            if (count_s) begin
                commit_cnt_r <= commit_cnt_r + 16'd1;
            end
        end
    end

    // Register array; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (we_onehot_s[i]) begin
                    regs_r[i] <= pend_data_r;
                end
            end
        end
    end

    // Combinational read port
    always_comb begin
        rd_data_s = regs_r[rd_addr];
`ifdef REGFILE_WR_BYPASS_EN
        if ((state_r != ST_IDLE) && (rd_addr == pend_addr_r) && (pend_addr_r != 5'd0)) begin
            rd_data_s = pend_data_r;
        end else begin
            rd_data_s = regs_r[rd_addr];
        end
`else
        rd_data_s = regs_r[rd_addr];
`endif
    end

    assign wr_ready   = wr_ready_s;
    assign we_onehot  = we_onehot_s;
    assign commit_cnt = commit_cnt_r;
    assign busy       = (state_r != ST_IDLE);
    assign rd_data    = rd_data_s;

endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed table-driven bench for regfile_write_demux plus wrap and reset sequences.
module tb_regfile_write_demux;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        freeze;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] we_onehot;
    logic [15:0] commit_cnt;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        f;
        logic [4:0]  ra;
        logic        e_rdy;
        logic        e_busy;
        logic [31:0] e_we;
        logic [31:0] e_rd;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    regfile_write_demux #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .freeze     (freeze),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .we_onehot  (we_onehot),
        .commit_cnt (commit_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [4:0] a, input logic [31:0] d, input logic f,
                       input logic [4:0] ra, input logic e_rdy, input logic e_busy,
                       input logic [31:0] e_we, input logic [31:0] e_rd, input logic [15:0] e_cnt);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.f = f; t.ra = ra;
        t.e_rdy = e_rdy; t.e_busy = e_busy; t.e_we = e_we; t.e_rd = e_rd; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        freeze = 1'b0; rd_addr = 5'd0;

        // Each row: inputs before an edge, outputs expected just before that edge
        //   v     a      d              f     ra     rdy   busy  we             rd                                   cnt
        add(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0,        32'h0,                                16'd0);
        add(1'b0, 5'd0, 32'h0,        1'b0, 5'd6, 1'b1, 1'b1, 32'h00000020, 32'h0,                                16'd0);
        add(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0,        32'hDEADBEEF,                         16'd1);
        add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 32'h0,        32'h0,                                16'd1);
        add(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd7, 1'b1, 1'b0, 32'h0,        32'h0,                                16'd1);
        add(1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF,                         16'd1);
        add(1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF,                         16'd1);
        add(1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF,                         16'd1);
        add(1'b1, 5'd3, 32'hBAD0BAD0, 1'b0, 5'd5, 1'b0, 1'b1, 32'h00000080, 32'hDEADBEEF,                         16'd1);
        add(1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 1'b1, 1'b0, 32'h0,        32'h00000077,                         16'd2);
        add(1'b1, 5'd3, 32'hAAAA0001, 1'b0, 5'd3, 1'b1, 1'b0, 32'h0,        32'h0,                                16'd2);
        add(1'b1, 5'd3, 32'hBBBB0002, 1'b0, 5'd7, 1'b1, 1'b1, 32'h00000008, 32'h00000077,                         16'd2);
        add(1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 1'b1, 1'b1, 32'h00000008, BYP ? 32'hBBBB0002 : 32'hAAAA0001,    16'd3);
        add(1'b1, 5'd4, 32'h00000044, 1'b0, 5'd3, 1'b1, 1'b0, 32'h0,        32'hBBBB0002,                         16'd4);
        add(1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 1'b1, 1'b1, 32'h00000010, BYP ? 32'h00000044 : 32'h0,           16'd4);
        add(1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd4, 1'b1, 1'b0, 32'h0,        32'h00000044,                         16'd5);
        add(1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 1'b1, 1'b1, 32'h00000010, BYP ? 32'hA5A5A5A5 : 32'h00000044,    16'd5);
        add(1'b0, 5'd0, 32'h0,        1'b0, 5'd4, 1'b1, 1'b0, 32'h0,        32'hA5A5A5A5,                         16'd6);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", we_onehot, 32'd0);
        chk("rst_cnt", 32'(commit_cnt), 32'd0);
        chk("rst_rd5", rd_data, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wr_valid = vecs[i].v; wr_addr = vecs[i].a; wr_data = vecs[i].d;
            freeze = vecs[i].f; rd_addr = vecs[i].ra;
            #2;
            chk($sformatf("v%0d_ready", i), 32'(wr_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_we", i), we_onehot, vecs[i].e_we);
            chk($sformatf("v%0d_rd", i), rd_data, vecs[i].e_rd);
            chk($sformatf("v%0d_cnt", i), 32'(commit_cnt), 32'(vecs[i].e_cnt));
        end

        // Counter wrap: stream back-to-back writes to reg 1 (one commit per edge after the first)
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 32'h00000011; freeze = 1'b0; rd_addr = 5'd1;
        repeat (65530) @(posedge clk);
        @(negedge clk);
        chk("wrap_ffff", 32'(commit_cnt), 32'h0000FFFF);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_zero", 32'(commit_cnt), 32'h00000000);
        wr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_drain_cnt", 32'(commit_cnt), 32'h00000001);
        chk("wrap_drain_busy", 32'(busy), 32'd0);
        chk("wrap_reg1", rd_data, 32'h00000011);

        // Reset while a write to reg 9 sits in HOLD
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h99999999; freeze = 1'b0; rd_addr = 5'd1;
        @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0; freeze = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_ready", 32'(wr_ready), 32'd0);
        freeze = 1'b0; rd_addr = 5'd9;
        #1;
        chk("hold_we9", we_onehot, 32'h00000200);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd1);
        chk("arst_we", we_onehot, 32'd0);
        chk("arst_cnt", 32'(commit_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("arst_reg9", rd_data, 32'd0);
        chk("arst_idle", 32'(busy), 32'd0);
        rd_addr = 5'd5;
        #1;
        chk("arst_reg5", rd_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_demux.md
REGFILE_WRITE_DEMUX -- requirements
Module: regfile_write_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and write-data width in bits.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_valid  input  1  write request present.
REQ-005 SHALL have port wr_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port wr_addr  input  5  destination register index.
REQ-007 SHALL have port wr_data  input  DATA_W  write data.
REQ-008 SHALL have port freeze  input  1  datapath stall; blocks commit.
REQ-009 SHALL have port rd_addr  input  5  read-back index.
REQ-010 SHALL have port rd_data  output  DATA_W  read-back data, combinational.
REQ-011 SHALL have port we_onehot  output  32  decoded write enable for the commit at the next edge.
REQ-012 SHALL have port commit_cnt  output  16  count of non-zero-index commits.
REQ-013 SHALL have port busy  output  1  a write is pending (state PEND or HOLD).

Function
REQ-014 SHALL accept a request on a rising edge where wr_valid and wr_ready are both 1, capturing wr_addr and wr_data into a pending register.
REQ-015 SHALL implement states IDLE, PEND and HOLD.
REQ-016 SHALL drive wr_ready = 1 in IDLE, = !freeze in PEND and = 0 in HOLD.
REQ-017 SHALL transition IDLE->PEND on accept and otherwise stay in IDLE.
REQ-018 SHALL, in PEND with freeze=0, commit the pending write at the edge and go to PEND on a simultaneous accept, else to IDLE.
REQ-019 SHALL, in PEND with freeze=1, go to HOLD without committing.
REQ-020 SHALL, in HOLD, stay while freeze=1, and commit then go to IDLE when freeze=0.
REQ-021 SHALL drive we_onehot as the one-hot decode of the pending address only when a commit occurs at the next edge (PEND or HOLD with freeze=0), otherwise all zero.
REQ-022 SHALL force we_onehot to zero for pending address 0; such a commit is discarded and not counted.
REQ-023 SHALL write wr_data into register[addr] at the commit edge; register 0 always reads zero.
REQ-024 SHALL have commit latency of exactly 1 edge after accept when freeze=0, so data is visible on rd_data one cycle after the accept edge.
REQ-025 SHALL increment commit_cnt by 1 per counted commit and wrap from 0xFFFF to 0x0000.
REQ-026 SHALL, on a back-to-back accept and commit of the same address, commit the older data and hold the newer data pending.

Reset
REQ-027 SHALL, with rst_n=0, immediately force state IDLE, all registers 0, the pending register 0 and commit_cnt 0; wr_ready=1, busy=0, we_onehot=0.
REQ-028 SHALL drop any pending write when reset is asserted mid-operation; it is never committed.

Configuration
REQ-029 SHALL, with macro REGFILE_WR_BYPASS_EN defined, return the pending data on rd_data when busy=1 and rd_addr equals a non-zero pending address.
REQ-030 SHALL, without REGFILE_WR_BYPASS_EN, return only committed register contents on rd_data.

Structure
REQ-031 SHALL place the state enum, NUM_REGS=32, ADDR_W=5 and CNT_W=16 in the shared package regfile_pkg.
REQ-032 SHALL implement the one-hot decode in sub-module decoder_5to32 (en, addr[4:0] -> onehot[31:0]).

Verification
REQ-033 SHALL cover: after reset, accept addr=5 data=0xDEADBEEF with freeze=0 -> we_onehot=0x00000020 for one cycle; rd_data(5)=0xDEADBEEF next cycle; commit_cnt=1.
REQ-034 SHALL cover: accept addr=0 data=0x12345678 -> we_onehot=0; rd_data(0)=0; commit_cnt unchanged.
REQ-035 SHALL cover: accept addr=7, then freeze=1 for 3 cycles -> state HOLD, wr_ready=0, no commit; freeze=0 -> commit, then IDLE.
REQ-036 SHALL cover: accept addr=3 with data A then B on consecutive cycles, freeze=0 -> rd_data(3)=A, then B; commit_cnt increments by 2.
REQ-037 SHALL cover: rst_n low while in HOLD with addr=9 pending -> register 9 stays 0; state IDLE.
REQ-038 SHALL cover: with REGFILE_WR_BYPASS_EN, rd_addr=4 while pending addr=4 data=0xA5A5A5A5 -> rd_data=0xA5A5A5A5 before commit; without the macro -> the old value.
